// File: rtl/tx_buff.sv
// rtl/tx_buff.sv - CAN transmit buffer: byte-serial host load, frame hold for the frame generator
module tx_buff #(
    parameter int BUSY_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       tx_buff_ld,
    output logic       frame_gen_intl,
    output logic       tx_buff_busy,
    output logic [7:0] tx_buff_1,
    output logic [7:0] tx_buff_2,
    output logic [7:0] tx_buff_3,
    output logic [7:0] tx_buff_4,
    output logic [7:0] tx_buff_5,
    output logic [7:0] tx_buff_6,
    output logic [7:0] tx_buff_7,
    output logic [7:0] tx_buff_8,
    output logic [7:0] tx_buff_9,
    output logic [7:0] tx_buff_10,
    output logic       rtr,
    output logic [3:0] dlc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;
    localparam int         HW     = $clog2(BUSY_CYCLES + 1);

    logic [1:0]    r_state;
    logic [3:0]    r_ptr;
    logic [3:0]    r_total;
    logic [HW-1:0] r_hold;
    logic          r_intl;
    logic [7:0]    r_buf [10];

    logic [3:0]    w_ndata;
    logic [3:0]    w_total;
    logic          w_last;

    // Frame length is fixed by the header byte on the edge it is written, so
    // a two-byte frame can complete on that same edge.
    always_comb begin
        w_ndata = 4'd0;
        if (!data_in[4])
            w_ndata = data_in[3] ? 4'd8 : data_in[3:0];
        w_total = (r_ptr == 4'd1) ? (4'd2 + w_ndata) : r_total;
        w_last  = (r_ptr != 4'd0) && ((r_ptr + 4'd1) == w_total);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 4'd0;
            r_total <= 4'd0;
            r_hold  <= '0;
            r_intl  <= 1'b0;
            for (int i = 0; i < 10; i++)
                r_buf[i] <= 8'd0;
        end else begin
            r_intl <= 1'b0;
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (tx_buff_ld) begin
                        if (r_ptr == 4'd0) begin
                            for (int i = 1; i < 10; i++)
                                r_buf[i] <= 8'd0;
                        end
                        r_buf[r_ptr] <= data_in;
                        r_ptr        <= r_ptr + 4'd1;
                        if (r_ptr == 4'd1)
                            r_total <= w_total;
                        if (w_last) begin
                            r_state <= S_BUSY;
                            r_intl  <= 1'b1;
                            r_hold  <= HW'(BUSY_CYCLES - 1);
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_hold == '0) begin
                        r_state <= S_IDLE;
                        r_ptr   <= 4'd0;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign frame_gen_intl = r_intl;
    assign tx_buff_busy   = (r_state == S_BUSY);
    assign tx_buff_1      = r_buf[0];
    assign tx_buff_2      = r_buf[1];
    assign tx_buff_3      = r_buf[2];
    assign tx_buff_4      = r_buf[3];
    assign tx_buff_5      = r_buf[4];
    assign tx_buff_6      = r_buf[5];
    assign tx_buff_7      = r_buf[6];
    assign tx_buff_8      = r_buf[7];
    assign tx_buff_9      = r_buf[8];
    assign tx_buff_10     = r_buf[9];
    assign rtr            = r_buf[1][4];
    assign dlc            = r_buf[1][3:0];

endmodule

// File: tb/tb_tx_buff.sv
// tb/tb_tx_buff.sv - directed vector bench for tx_buff
module tb_tx_buff;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       tx_buff_ld = 1'b0;
    logic       frame_gen_intl, tx_buff_busy, rtr;
    logic [3:0] dlc;
    logic [7:0] ob [10];

    always #5 clk = ~clk;

    tx_buff #(.BUSY_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .tx_buff_ld(tx_buff_ld),
        .frame_gen_intl(frame_gen_intl), .tx_buff_busy(tx_buff_busy),
        .tx_buff_1(ob[0]), .tx_buff_2(ob[1]), .tx_buff_3(ob[2]), .tx_buff_4(ob[3]),
        .tx_buff_5(ob[4]), .tx_buff_6(ob[5]), .tx_buff_7(ob[6]), .tx_buff_8(ob[7]),
        .tx_buff_9(ob[8]), .tx_buff_10(ob[9]), .rtr(rtr), .dlc(dlc)
    );

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] din;
        logic       intl;
        logic       busy;
        int         idx;
        logic [7:0] val;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic l, input logic [7:0] d,
                       input logic i, input logic b, input int x, input logic [7:0] v);
        vec_t t;
        t.rst = r; t.ld = l; t.din = d; t.intl = i; t.busy = b; t.idx = x; t.val = v;
        vecs.push_back(t);
    endtask

    task automatic step(input logic r, input logic l, input logic [7:0] d);
        reset = r;
        tx_buff_ld = l;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input int a, input int b);
        for (int k = a; k < b; k++) begin
            step(vecs[k].rst, vecs[k].ld, vecs[k].din);
            chk($sformatf("v%0d intl", k), 8'(frame_gen_intl), 8'(vecs[k].intl));
            chk($sformatf("v%0d busy", k), 8'(tx_buff_busy), 8'(vecs[k].busy));
            if (vecs[k].idx != 0)
                chk($sformatf("v%0d tx_buff_%0d", k, vecs[k].idx), ob[vecs[k].idx-1], vecs[k].val);
        end
    endtask

    initial begin
        logic [7:0] exp_a [10];
        int a_end, b_end, c_end, d_end, e_end;
        exp_a = '{8'h12, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

        // full ten-byte frame after reset
        add(1, 0, 8'h00, 0, 0, 1, 8'h00);
        for (int k = 0; k < 10; k++)
            add(0, 1, exp_a[k], k == 9, k == 9, k + 1, exp_a[k]);
        a_end = vecs.size();
        // reset beats a load, then short frame with a gap
        add(1, 1, 8'h34, 0, 0, 1, 8'h00);
        add(0, 1, 8'h34, 0, 0, 1, 8'h34);
        add(0, 1, 8'h02, 0, 0, 2, 8'h02);
        add(0, 1, 8'hC1, 0, 0, 3, 8'hC1);
        add(0, 0, 8'h99, 0, 0, 4, 8'h00);
        add(0, 1, 8'hC2, 1, 1, 4, 8'hC2);
        b_end = vecs.size();
        // remote frame completes on the header
        add(1, 0, 8'h00, 0, 0, 1, 8'h00);
        add(0, 1, 8'h56, 0, 0, 1, 8'h56);
        add(0, 1, 8'h18, 1, 1, 2, 8'h18);
        c_end = vecs.size();
        // DLC 15 clamps to eight data bytes
        add(1, 0, 8'h00, 0, 0, 1, 8'h00);
        add(0, 1, 8'h00, 0, 0, 1, 8'h00);
        add(0, 1, 8'h0F, 0, 0, 2, 8'h0F);
        for (int k = 0; k < 8; k++)
            add(0, 1, 8'hA1 + 8'(k), k == 7, k == 7, k + 3, 8'hA1 + 8'(k));
        d_end = vecs.size();
        // abort mid-frame, then a DLC=0 frame
        add(1, 0, 8'h00, 0, 0, 1, 8'h00);
        add(0, 1, 8'h12, 0, 0, 1, 8'h12);
        add(0, 1, 8'hAA, 0, 0, 2, 8'hAA);
        add(0, 1, 8'h01, 0, 0, 3, 8'h01);
        add(0, 1, 8'h02, 0, 0, 4, 8'h02);
        add(0, 1, 8'h03, 0, 0, 5, 8'h03);
        add(1, 0, 8'h00, 0, 0, 3, 8'h00);
        add(0, 1, 8'h77, 0, 0, 1, 8'h77);
        add(0, 1, 8'h00, 1, 1, 2, 8'h00);
        e_end = vecs.size();

        run(0, a_end);
        for (int k = 0; k < 10; k++)
            chk($sformatf("A tx_buff_%0d", k + 1), ob[k], exp_a[k]);
        chk("A rtr", 8'(rtr), 8'h00);
        chk("A dlc", 8'(dlc), 8'h0A);
        for (int c = 2; c <= 16; c++) begin
            step(0, 1, 8'hFF);
            chk($sformatf("A busy c%0d", c), 8'(tx_buff_busy), 8'h01);
            chk($sformatf("A intl c%0d", c), 8'(frame_gen_intl), 8'h00);
            chk($sformatf("A hold1 c%0d", c), ob[0], 8'h12);
            chk($sformatf("A hold10 c%0d", c), ob[9], 8'h08);
        end
        step(0, 1, 8'hFF);
        chk("A busy drop", 8'(tx_buff_busy), 8'h00);
        chk("A drop hold1", ob[0], 8'h12);
        step(0, 1, 8'hFF);
        chk("A new byte1", ob[0], 8'hFF);
        for (int k = 1; k < 10; k++)
            chk($sformatf("A cleared tx_buff_%0d", k + 1), ob[k], 8'h00);
        chk("A new busy", 8'(tx_buff_busy), 8'h00);

        run(a_end, b_end);
        chk("B dlc", 8'(dlc), 8'h02);
        chk("B rtr", 8'(rtr), 8'h00);
        for (int k = 4; k < 10; k++)
            chk($sformatf("B tx_buff_%0d", k + 1), ob[k], 8'h00);
        step(0, 0, 8'h00);
        chk("B intl fall", 8'(frame_gen_intl), 8'h00);
        chk("B busy held", 8'(tx_buff_busy), 8'h01);

        run(b_end, c_end);
        chk("C rtr", 8'(rtr), 8'h01);
        chk("C dlc", 8'(dlc), 8'h08);
        step(0, 1, 8'h33);
        chk("C lockout tx_buff_3", ob[2], 8'h00);
        chk("C intl fall", 8'(frame_gen_intl), 8'h00);

        run(c_end, d_end);
        chk("D dlc raw", 8'(dlc), 8'h0F);

        run(d_end, e_end);
        chk("E dlc", 8'(dlc), 8'h00);
        for (int k = 2; k < 10; k++)
            chk($sformatf("E tx_buff_%0d", k + 1), ob[k], 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
